// File: rtl/axi_reg_slice.sv
// axi_reg_slice: one configurable pipeline stage on each AXI4 channel
// (AW, W, B, AR, R) between a master (s_ side) and a controller front end
// (m_ side). AW/W/AR flow s -> m, B/R flow m -> s.
//
// Handshake semantics (all channels, both sides): a beat transfers on a
// rising clk edge where valid and ready are both high. Once valid is high it
// stays high, and the payload stays stable, until ready is sampled high.
// Ready may be asserted independently of valid. Beat order is preserved and
// payloads are never modified.
//
// Per-channel MODE: 0 = combinational bypass, 1 = 2-entry skid buffer with a
// registered ready (full throughput), 2 = single register (half throughput).
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   s_aw_*, m_aw_*               AW in (master) / out (controller)
//   s_w_*,  m_w_*                W  in (master) / out (controller)
//   s_ar_*, m_ar_*               AR in (master) / out (controller)
//   m_b_*,  s_b_*                B  in (controller) / out (master)
//   m_r_*,  s_r_*                R  in (controller) / out (master)
//   idle                         high when no registered stage holds a beat

module axi_reg_slice_stage #(
  parameter int W    = 8,
  parameter int MODE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  generate
    if (MODE == 0) begin : g_bypass
      // No storage: clock and reset are intentionally unused.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign in_ready  = out_ready;
      assign busy      = 1'b0;
    end else if (MODE == 1) begin : g_full
      logic         main_valid;
      logic         skid_valid;
      logic         ready_q;
      logic [W-1:0] main_data;
      logic [W-1:0] skid_data;
      logic         push;
      logic         pop;
      logic         main_valid_nxt;
      logic         skid_valid_nxt;

      assign push = in_valid && ready_q;
      assign pop  = main_valid && out_ready;

      // Main always holds the oldest beat; skid only fills while main is full.
      always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        if (pop) begin
          if (skid_valid) begin
            main_valid_nxt = 1'b1;
            skid_valid_nxt = push;
          end else begin
            main_valid_nxt = push;
          end
        end else if (push) begin
          if (main_valid) skid_valid_nxt = 1'b1;
          else            main_valid_nxt = 1'b1;
        end
      end

      // Ready is computed from the post-edge occupancy so that it is already
      // low in the cycle after the second entry lands.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          ready_q    <= 1'b0;
        end else begin
          main_valid <= main_valid_nxt;
          skid_valid <= skid_valid_nxt;
          ready_q    <= !(main_valid_nxt && skid_valid_nxt);
        end
      end

      // Payload registers carry no reset; their content is ignored while
      // the matching valid bit is low.
      always_ff @(posedge clk) begin
        if (pop) begin
          if (skid_valid) begin
            main_data <= skid_data;
            if (push) skid_data <= in_data;
          end else if (push) begin
            main_data <= in_data;
          end
        end else if (push) begin
          if (main_valid) skid_data <= in_data;
          else            main_data <= in_data;
        end
      end

      assign in_ready  = ready_q;
      assign out_valid = main_valid;
      assign out_data  = main_data;
      assign busy      = main_valid;
    end else if (MODE == 2) begin : g_light
      logic         valid_q;
      logic [W-1:0] data_q;
      logic         push;
      logic         pop;

      // Ready is the inverse of the occupancy flop, so push and pop can
      // never coincide: one beat per two cycles.
      assign push = in_valid && !valid_q;
      assign pop  = valid_q && out_ready;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
        end else if (push) begin
          valid_q <= 1'b1;
        end else if (pop) begin
          valid_q <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (push) data_q <= in_data;
      end

      assign in_ready  = !valid_q;
      assign out_valid = valid_q;
      assign out_data  = data_q;
      assign busy      = valid_q;
    end else begin : g_bad_mode
      $error("axi_reg_slice_stage: illegal MODE %0d (legal: 0, 1, 2)", MODE);
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, in_valid, out_ready, in_data};
      assign in_ready  = 1'b0;
      assign out_valid = 1'b0;
      assign out_data  = '0;
      assign busy      = 1'b0;
    end
  endgenerate

endmodule

module axi_reg_slice #(
  parameter  int DATA_W  = 256,
  parameter  int ADDR_W  = 32,
  parameter  int ID_W    = 1,
  parameter  int AW_MODE = 1,
  parameter  int W_MODE  = 1,
  parameter  int B_MODE  = 1,
  parameter  int AR_MODE = 1,
  parameter  int R_MODE  = 1,
  localparam int AX_W    = ADDR_W + ID_W + 29,
  localparam int W_W     = DATA_W + DATA_W / 8 + ID_W + 2,
  localparam int B_W     = ID_W + 4,
  localparam int R_W     = DATA_W + ID_W + 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_aw_valid,
  input  logic [AX_W-1:0] s_aw_payload,
  output logic            s_aw_ready,
  output logic            m_aw_valid,
  output logic [AX_W-1:0] m_aw_payload,
  input  logic            m_aw_ready,
  input  logic            s_w_valid,
  input  logic [W_W-1:0]  s_w_payload,
  output logic            s_w_ready,
  output logic            m_w_valid,
  output logic [W_W-1:0]  m_w_payload,
  input  logic            m_w_ready,
  input  logic            s_ar_valid,
  input  logic [AX_W-1:0] s_ar_payload,
  output logic            s_ar_ready,
  output logic            m_ar_valid,
  output logic [AX_W-1:0] m_ar_payload,
  input  logic            m_ar_ready,
  input  logic            m_b_valid,
  input  logic [B_W-1:0]  m_b_payload,
  output logic            m_b_ready,
  output logic            s_b_valid,
  output logic [B_W-1:0]  s_b_payload,
  input  logic            s_b_ready,
  input  logic            m_r_valid,
  input  logic [R_W-1:0]  m_r_payload,
  output logic            m_r_ready,
  output logic            s_r_valid,
  output logic [R_W-1:0]  s_r_payload,
  input  logic            s_r_ready,
  output logic            idle
);

  generate
    if (DATA_W != 32 && DATA_W != 64 && DATA_W != 128 &&
        DATA_W != 256 && DATA_W != 512) begin : g_bad_data_w
      $error("axi_reg_slice: illegal DATA_W %0d", DATA_W);
    end
  endgenerate

  logic aw_busy;
  logic w_busy;
  logic b_busy;
  logic ar_busy;
  logic r_busy;

  axi_reg_slice_stage #(.W(AX_W), .MODE(AW_MODE)) u_aw (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_aw_valid),
    .in_ready  (s_aw_ready),
    .in_data   (s_aw_payload),
    .out_valid (m_aw_valid),
    .out_ready (m_aw_ready),
    .out_data  (m_aw_payload),
    .busy      (aw_busy)
  );

  axi_reg_slice_stage #(.W(W_W), .MODE(W_MODE)) u_w (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_w_valid),
    .in_ready  (s_w_ready),
    .in_data   (s_w_payload),
    .out_valid (m_w_valid),
    .out_ready (m_w_ready),
    .out_data  (m_w_payload),
    .busy      (w_busy)
  );

  axi_reg_slice_stage #(.W(AX_W), .MODE(AR_MODE)) u_ar (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_ar_valid),
    .in_ready  (s_ar_ready),
    .in_data   (s_ar_payload),
    .out_valid (m_ar_valid),
    .out_ready (m_ar_ready),
    .out_data  (m_ar_payload),
    .busy      (ar_busy)
  );

  axi_reg_slice_stage #(.W(B_W), .MODE(B_MODE)) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_b_valid),
    .in_ready  (m_b_ready),
    .in_data   (m_b_payload),
    .out_valid (s_b_valid),
    .out_ready (s_b_ready),
    .out_data  (s_b_payload),
    .busy      (b_busy)
  );

  axi_reg_slice_stage #(.W(R_W), .MODE(R_MODE)) u_r (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_r_valid),
    .in_ready  (m_r_ready),
    .in_data   (m_r_payload),
    .out_valid (s_r_valid),
    .out_ready (s_r_ready),
    .out_data  (s_r_payload),
    .busy      (r_busy)
  );

  assign idle = !(aw_busy || w_busy || b_busy || ar_busy || r_busy);

endmodule

// File: doc/axi_reg_slice.md
# axi_reg_slice

Parametrised AXI4 register slice: one independently configurable pipeline stage on each of the five AXI channels (AW, W, B, AR, R) between an AXI master and the controller's AXI front end. Data, address and ID widths are generic. Each channel can be a combinational bypass, a full-throughput 2-entry skid buffer, or a half-throughput 1-entry stage. An `idle` flag reports when every stage is empty, for drain checks before refresh or self-refresh entry.

## Interface
Parameters:
- DATA_W, 256, data width; legal values 32/64/128/256/512.
- ADDR_W, 32, address width.
- ID_W, 1, ID width.
- AW_MODE / W_MODE / B_MODE / AR_MODE / R_MODE, 1, per-channel mode: 0 = bypass, 1 = full (2-entry skid), 2 = light (1 entry).

Derived payload widths, packed MSB→LSB:
- AX_W = ADDR_W+ID_W+29: {addr, burst[1:0], len[7:0], size[3:0], lock[1:0], prot[2:0], cache[3:0], qos[3:0], id, first, last}.
- W_W = DATA_W+DATA_W/8+ID_W+2: {data, strb, id, first, last}.
- B_W = ID_W+4: {resp[1:0], id, first, last}.
- R_W = DATA_W+ID_W+4: {data, resp[1:0], id, first, last}.

Ports (s_ = master side, m_ = controller side):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_aw_valid, s_aw_payload  in  1, AX_W  AW from master.
- s_aw_ready  out  1.
- m_aw_valid, m_aw_payload  out  1, AX_W  AW to controller.
- m_aw_ready  in  1.
- s_w_valid, s_w_payload  in  1, W_W; s_w_ready  out  1.
- m_w_valid, m_w_payload  out  1, W_W; m_w_ready  in  1.
- s_ar_valid, s_ar_payload  in  1, AX_W; s_ar_ready  out  1.
- m_ar_valid, m_ar_payload  out  1, AX_W; m_ar_ready  in  1.
- m_b_valid, m_b_payload  in  1, B_W; m_b_ready  out  1  B from controller.
- s_b_valid, s_b_payload  out  1, B_W; s_b_ready  in  1  B to master.
- m_r_valid, m_r_payload  in  1, R_W; m_r_ready  out  1.
- s_r_valid, s_r_payload  out  1, R_W; s_r_ready  in  1.
- idle  out  1  high when no registered stage holds an entry.

## Operation
- Each channel is one generic slice instance with in_valid/in_ready/in_data → out_valid/out_ready/out_data. AW/W/AR flow s→m; B/R flow m→s.
- Transfer occurs on an edge where valid && ready are both high. Order is strictly preserved. Payload is never modified.
- Mode 0 (bypass): out = in and in_ready = out_ready, combinationally. There is no storage, so the slice contributes nothing to `idle`.
- Mode 1 (full): main register plus skid register; count ∈ {0,1,2}.
  - in_ready is registered and equals (count<2) as of the previous edge, i.e. no combinational ready path.
  - Push with count=2 cannot occur. Push and pop on the same edge leave count unchanged.
  - When the main register pops while the skid register is full, the skid entry moves to main on that edge.
- Mode 2 (light): a single register.
  - in_ready = !out_valid (combinational from the flop).
  - Simultaneous push and pop is not allowed. The next entry is accepted the cycle after the pop, giving 1 transfer per 2 cycles.
- out_valid, once high, stays high and out_data stays stable until out_ready is sampled high. This is the AXI stability rule, and the slice guarantees it.
- idle = no valid bit set in any mode-1 or mode-2 slice.
- Illegal mode value (>2): elaboration-time $error.

## Timing
- Reset (rst=0, asynchronous): all valid flops, count, skid-full and registered ready flops clear.
  - Outputs during reset: every m_/s_ *_valid = 0, all registered *_ready = 0, idle = 1.
  - Payload flops are not reset; their content is don't-care while valid=0.
- First rising edge with rst=1: registered ready rises to 1, so it is first sampled high on the second edge.
- Latency, mode 1/2: input handshake at edge N → out_valid high after edge N, so it is visible for the edge N+1 handshake.
- Latency, mode 0: 0 cycles.
- Throughput: mode 1 sustains 1 beat/cycle with out_ready held high. Mode 2 sustains 0.5 beat/cycle.
- Backpressure, mode 1: out_ready low → at most 2 entries are accepted, and in_ready drops the edge after the second push. out_ready high again → one pop per cycle, and in_ready returns the edge after count falls below 2.
- Reset asserted mid-burst: entries are discarded immediately, with no partial beat presented.

## Test plan
- Reset: hold rst=0 for 3 cycles, release → all valid=0 and idle=1 during reset; s_aw_ready=1 from the second edge after release.
- Full-mode stream: push 16 W beats (data = i, strb = all-ones, last on beat 15) with m_w_ready=1 → beats appear in order one cycle later, no bubbles, idle=1 afterwards.
- Skid backpressure, AR mode 1: m_ar_ready=0 and 4 requests offered → exactly 2 accepted, s_ar_ready=0. Release → addresses 0x100, 0x140, 0x180, 0x1C0 emitted in order, each stable while stalled.
- Light mode R (R_MODE=2): 8 beats with s_r_ready=1 → 8 beats take 16 cycles; m_r_ready is never high while s_r_valid=1 un-popped.
- Bypass B (B_MODE=0): random m_b_valid/s_b_ready → same-cycle pass-through of resp=2'b10, id=1; idle unaffected.
- Mid-burst reset: 2 entries buffered on AW, assert rst → m_aw_valid drops without waiting for clk; after release, no stale entry appears.
